phase_sequencer: RTL and testbench

//  Parametrised multi-phase control sequencer for the piano audio datapath.

---
 rtl/phase_sequencer.sv | 133 +++++++++++++
 tb/tb_phase_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: steps through NUM_PHASES one-hot phase enables, each held for a
// programmable dwell and optionally until a per-phase ack; one frame per tick or back-to-back.
module phase_sequencer #(
  parameter int                    NUM_PHASES = 2,
  parameter int                    DWELL_W    = 8,
  parameter logic [NUM_PHASES-1:0] WAIT_MASK  = '0,
  parameter int                    IDX_W      = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sample_tick,
  input  logic                          continuous,
  input  logic                          clr_overrun,
  input  logic [NUM_PHASES*DWELL_W-1:0] dwell,
  input  logic [NUM_PHASES-1:0]         phase_ack,
  output logic [NUM_PHASES-1:0]         phase_en,
  output logic [IDX_W-1:0]              phase_idx,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DWELL_W-1:0]    cnt_q, cnt_d;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;

  logic                  advance;
  logic                  enter;
  logic [IDX_W-1:0]      enter_idx;
  logic [DWELL_W-1:0]    dwell_sel;

  // cnt_q holds the dwell cycles still to go after the current one, so it is
  // loaded with max(dwell,1)-1 on phase entry.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;
    enter        = 1'b0;
    enter_idx    = '0;
    dwell_sel    = '0;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick || continuous) enter = 1'b1;
      end
      ST_RUN: begin
        if (cnt_q != '0)             cnt_d   = cnt_q - 1'b1;
        else if (WAIT_MASK[idx_q])   state_d = ST_WAIT_ACK;
        else                         advance = 1'b1;
      end
      ST_WAIT_ACK: begin
        if (phase_ack[idx_q]) advance = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        frame_done_d = 1'b1;
        if (continuous) begin
          enter = 1'b1;
        end else begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end else begin
        enter     = 1'b1;
        enter_idx = idx_q + 1'b1;
      end
    end

    for (int i = 0; i < NUM_PHASES; i++) begin
      if (enter_idx == IDX_W'(i)) dwell_sel = dwell[i*DWELL_W +: DWELL_W];
    end

    if (enter) begin
      state_d = ST_RUN;
      idx_d   = enter_idx;
      cnt_d   = (dwell_sel == '0) ? '0 : dwell_sel - 1'b1;
    end
  end

  // Overrun set takes priority over a same-cycle clear.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    phase_en_d = busy_d ? (NUM_PHASES'(1) << idx_d) : '0;
    overrun_d  = (busy_q & sample_tick & ~continuous) | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      phase_en_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      phase_en_q   <= phase_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign phase_en   = phase_en_q;
  assign phase_idx  = idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: drives three sequencer configurations from shared stimulus and
// compares every cycle against a phase-level reference model.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sample_tick;
  logic        continuous;
  logic        clr_overrun;
  logic [31:0] dwell4;
  logic [3:0]  ack4;

  logic [1:0] en_def;  logic [0:0] idx_def; logic busy_def, fd_def, ov_def;
  logic [3:0] en4;     logic [1:0] idx4;    logic busy4, fd4, ov4;
  logic [1:0] en_w;    logic [0:0] idx_w;   logic busy_w, fd_w, ov_w;

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  phase_sequencer u_def (
    .clk(clk), .resetn(resetn), .sample_tick(sample_tick), .continuous(continuous),
    .clr_overrun(clr_overrun), .dwell(dwell4[15:0]), .phase_ack(ack4[1:0]),
    .phase_en(en_def), .phase_idx(idx_def), .busy(busy_def), .frame_done(fd_def),
    .overrun(ov_def)
  );

  phase_sequencer #(.NUM_PHASES(4)) u_four (
    .clk(clk), .resetn(resetn), .sample_tick(sample_tick), .continuous(continuous),
    .clr_overrun(clr_overrun), .dwell(dwell4), .phase_ack(ack4),
    .phase_en(en4), .phase_idx(idx4), .busy(busy4), .frame_done(fd4),
    .overrun(ov4)
  );

  phase_sequencer #(.NUM_PHASES(2), .WAIT_MASK(2'b10)) u_wait (
    .clk(clk), .resetn(resetn), .sample_tick(sample_tick), .continuous(continuous),
    .clr_overrun(clr_overrun), .dwell(dwell4[15:0]), .phase_ack(ack4[1:0]),
    .phase_en(en_w), .phase_idx(idx_w), .busy(busy_w), .frame_done(fd_w),
    .overrun(ov_w)
  );

  // Reference model: active phase (-1 = idle), cycles spent in it, its length,
  // and whether the ack hold has started.
  int         m_cur  [3];
  int         m_el   [3];
  int         m_len  [3];
  bit         m_wait [3];
  bit         m_fd   [3];
  bit         m_ov   [3];
  int         m_np   [3];
  logic [3:0] m_mask [3];

  initial begin
    m_np   = '{2, 4, 2};
    m_mask = '{4'b0000, 4'b0000, 4'b0010};
    for (int k = 0; k < 3; k++) begin
      m_cur[k] = -1; m_el[k] = 0; m_len[k] = 1;
      m_wait[k] = 0; m_fd[k] = 0; m_ov[k] = 0;
    end
  end

  task automatic model_step(input int k);
    int   nxt;
    bit   entering;
    bit   set_ov;
    logic [7:0] d;
    if (!resetn) begin
      m_cur[k] = -1; m_fd[k] = 0; m_ov[k] = 0; m_wait[k] = 0;
      return;
    end
    set_ov   = (m_cur[k] >= 0) && sample_tick && !continuous;
    m_fd[k]  = 0;
    nxt      = m_cur[k];
    entering = 0;
    if (m_cur[k] < 0) begin
      if (sample_tick || continuous) begin nxt = 0; entering = 1; end
    end else if (m_el[k] < m_len[k]) begin
      m_el[k]++;
    end else if (m_mask[k][m_cur[k]] && !m_wait[k]) begin
      m_wait[k] = 1;
    end else if (!m_mask[k][m_cur[k]] || ack4[m_cur[k]]) begin
      if (m_cur[k] == m_np[k] - 1) begin
        m_fd[k] = 1;
        if (continuous) begin nxt = 0; entering = 1; end
        else nxt = -1;
      end else begin
        nxt = m_cur[k] + 1; entering = 1;
      end
    end
    if (entering) begin
      d         = dwell4[nxt*8 +: 8];
      m_len[k]  = (d == 0) ? 1 : int'(d);
      m_el[k]   = 1;
      m_wait[k] = 0;
    end
    m_cur[k] = nxt;
    m_ov[k]  = set_ov ? 1'b1 : (clr_overrun ? 1'b0 : m_ov[k]);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cmpInst(input int k, input logic [3:0] en, input logic [1:0] idx,
                         input logic b, input logic f, input logic o);
    int cur;
    cur = m_cur[k];
    checkOutput($sformatf("u%0d.phase_en", k),   en,  (cur < 0) ? 0 : (1 << cur));
    checkOutput($sformatf("u%0d.phase_idx", k),  idx, (cur < 0) ? 0 : cur);
    checkOutput($sformatf("u%0d.busy", k),       b,   cur >= 0);
    checkOutput($sformatf("u%0d.frame_done", k), f,   m_fd[k]);
    checkOutput($sformatf("u%0d.overrun", k),    o,   m_ov[k]);
  endtask

  // Continuous model comparison on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (check_on) begin
      cmpInst(0, {2'b00, en_def}, {1'b0, idx_def}, busy_def, fd_def, ov_def);
      cmpInst(1, en4, idx4, busy4, fd4, ov4);
      cmpInst(2, {2'b00, en_w}, {1'b0, idx_w}, busy_w, fd_w, ov_w);
    end
  end

  task automatic applyStimulus(input bit tick, input bit clr, input logic [3:0] ack);
    sample_tick = tick;
    clr_overrun = clr;
    ack4        = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    resetn     = 1'b0;
    continuous = 1'b0;
    applyStimulus(0, 0, 4'b0000);
    resetn     = 1'b1;
  endtask

  int t2_idx [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 3};

  initial begin
    resetn = 1'b0; continuous = 1'b0; sample_tick = 1'b0; clr_overrun = 1'b0;
    dwell4 = '0; ack4 = '0;
    applyStimulus(0, 0, 4'b0000);
    check_on = 1'b1;
    applyStimulus(0, 0, 4'b0000);
    checkOutput("reset.phase_en", en4, 0);
    checkOutput("reset.phase_idx", idx4, 0);
    checkOutput("reset.busy", busy4, 0);
    checkOutput("reset.frame_done", fd4, 0);
    checkOutput("reset.overrun", ov4, 0);

    // Defaults in continuous mode alternate phases every cycle.
    resetn = 1'b1; dwell4 = 32'h01010101; continuous = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 4'b0000);
      checkOutput("t1.phase_en", en_def, (i % 2 == 0) ? 1 : 2);
      checkOutput("t1.frame_done", fd_def, (i >= 2) && (i % 2 == 0));
      checkOutput("t1.overrun", ov_def, 0);
    end

    // Single frame with mixed dwells; a phase-0 dwell edit after entry is ignored.
    doReset();
    dwell4 = 32'h01000503;
    applyStimulus(1, 0, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        checkOutput("t2.phase_idx", idx4, t2_idx[i]);
        checkOutput("t2.phase_en", en4, 1 << t2_idx[i]);
        checkOutput("t2.busy", busy4, 1);
        checkOutput("t2.frame_done", fd4, 0);
      end else begin
        checkOutput("t2.busy_end", busy4, 0);
        checkOutput("t2.frame_done_end", fd4, i == 10);
        checkOutput("t2.phase_en_end", en4, 0);
      end
      if (i == 0) dwell4[7:0] = 8'd9;
      applyStimulus(0, 0, 4'b0000);
    end

    // Ack-gated phase 1 held seven extra cycles; stray acks ignored.
    doReset();
    dwell4 = 32'h00000101;
    applyStimulus(1, 0, 4'b0001);
    checkOutput("t3.phase_en_c0", en_w, 2'b01);
    applyStimulus(0, 0, 4'b0001);
    checkOutput("t3.phase_en_c1", en_w, 2'b10);
    applyStimulus(0, 0, 4'b0010);
    checkOutput("t3.phase_en_c2", en_w, 2'b10);
    for (int j = 3; j <= 8; j++) begin
      applyStimulus(0, 0, (j % 2) ? 4'b0001 : 4'b0000);
      checkOutput("t3.phase_en_hold", en_w, 2'b10);
      checkOutput("t3.busy_hold", busy_w, 1);
    end
    applyStimulus(0, 0, 4'b0010);
    checkOutput("t3.busy_end", busy_w, 0);
    checkOutput("t3.frame_done_end", fd_w, 1);

    // Overrun set, no extra frame, clear, and set-beats-clear.
    doReset();
    dwell4 = 32'h02020202;
    applyStimulus(1, 0, 4'b0000);
    applyStimulus(0, 0, 4'b0000);
    applyStimulus(0, 0, 4'b0000);
    applyStimulus(1, 0, 4'b0000);
    checkOutput("t4.overrun_set", ov4, 1);
    checkOutput("t4.phase_idx", idx4, 1);
    repeat (5) applyStimulus(0, 0, 4'b0000);
    checkOutput("t4.busy_end", busy4, 0);
    checkOutput("t4.frame_done", fd4, 1);
    repeat (3) applyStimulus(0, 0, 4'b0000);
    checkOutput("t4.no_extra_frame", busy4, 0);
    applyStimulus(0, 1, 4'b0000);
    checkOutput("t4.overrun_clr", ov4, 0);
    applyStimulus(1, 0, 4'b0000);
    applyStimulus(1, 1, 4'b0000);
    checkOutput("t4.set_beats_clr", ov4, 1);
    applyStimulus(0, 1, 4'b0000);
    checkOutput("t4.overrun_clr2", ov4, 0);

    // Reset in phase 2 aborts the frame; the next tick restarts at phase 0.
    doReset();
    dwell4 = 32'h04040404;
    applyStimulus(1, 0, 4'b0000);
    repeat (7) applyStimulus(0, 0, 4'b0000);
    applyStimulus(1, 0, 4'b0000);
    checkOutput("t5.phase_idx", idx4, 2);
    checkOutput("t5.overrun", ov4, 1);
    resetn = 1'b0;
    applyStimulus(0, 0, 4'b0000);
    checkOutput("t5.rst_phase_en", en4, 0);
    checkOutput("t5.rst_phase_idx", idx4, 0);
    checkOutput("t5.rst_busy", busy4, 0);
    checkOutput("t5.rst_overrun", ov4, 0);
    resetn = 1'b1;
    applyStimulus(1, 0, 4'b0000);
    checkOutput("t5.restart_idx", idx4, 0);
    checkOutput("t5.restart_en", en4, 1);

    // Dropping continuous mid-frame lets the frame finish, then idles.
    doReset();
    dwell4 = 32'h02020202; continuous = 1'b1;
    repeat (3) applyStimulus(0, 0, 4'b0000);
    checkOutput("t6.phase_idx", idx4, 1);
    continuous = 1'b0;
    repeat (5) applyStimulus(0, 0, 4'b0000);
    checkOutput("t6.busy_last", busy4, 1);
    applyStimulus(0, 0, 4'b0000);
    checkOutput("t6.busy_end", busy4, 0);
    checkOutput("t6.frame_done", fd4, 1);
    repeat (3) applyStimulus(0, 0, 4'b0000);
    checkOutput("t6.no_restart", busy4, 0);

    // Randomised traffic, checked only by the model.
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      if ($urandom_range(0, 9) == 0)
        dwell4 = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                  8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
